fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 16-deep x 8-bit FIFO among N_REQ producers.
- Each producer has a valid/ready handshake.
- The winner holds the port for a burst of up to MAX_BURST beats.
- FIFO `full` is the backpressure, so the arbiter never causes an overflow.
- Sits between the producer blocks and the FIFO `wr`/`din`/`full` pins.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DW, 8, data width; must match the FIFO `din`
- MAX_BURST, 4, maximum beats per grant (1..16)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  N_REQ  per-requester data valid
- req_data  in  N_REQ*DW  requester i data on bits [i*DW +: DW]
- req_ready  out  N_REQ  per-requester accept; a beat transfers when valid && ready
- fifo_full  in  1  FIFO `full` flag
- fifo_wr  out  1  FIFO write strobe
- fifo_din  out  DW  FIFO write data
- gnt  out  N_REQ  one-hot current owner; all zero in IDLE
- busy  out  1  high in BURST state

Behaviour:
- Reset values, in the cycle after `rst` is sampled high:
  - state = IDLE, `gnt` = 0, `busy` = 0, beat_cnt = 0, last_gnt = N_REQ-1 (requester 0 has first priority).
  - `req_ready`, `fifo_wr` = 0; `fifo_din` = 0.
- Reset mid-burst: the burst is abandoned, no write is issued in the reset cycle and no state is retained.
- States: IDLE, BURST.
- IDLE:
  - If any `req_valid` is high, pick the first requester with valid high, searching last_gnt+1, last_gnt+2, ... modulo N_REQ.
  - Register the choice into `gnt` and last_gnt, clear beat_cnt, go to BURST.
  - No transfer occurs in IDLE; one arbitration bubble per grant.
  - If no `req_valid` is high, stay in IDLE.
- BURST, owner g:
  - `req_ready[g]` = !`fifo_full`; all other `req_ready` bits = 0.
  - `fifo_wr` = `req_valid[g]` && !`fifo_full`, combinational from the registered grant.
  - `fifo_din` = `req_data[g]` when `fifo_wr` is high, else 0.
  - Beat: `fifo_wr` high. beat_cnt increments; width is clog2(MAX_BURST+1).
  - Exit to IDLE, clearing `gnt`, at the clock edge where either:
    - a beat occurs and beat_cnt+1 == MAX_BURST, or
    - `req_valid[g]` is low (the owner has gone idle).
  - `fifo_full` high with `req_valid[g]` high is a stall: hold the grant, beat_cnt unchanged, no timeout.
- Overflow: `fifo_wr` is never high while `fifo_full` is high.
- FIFO `full` is derived from the registered count, so back-to-back writes into the last free entry are safe.
- Requests dropped while not owning the port are legal and carry no penalty.
- Data order per requester is preserved. Across requesters, order is grant order.
- Fairness: with all requesters continuously valid and the FIFO not full, grants rotate 0,1,...,N_REQ-1,0.
  - Each grant yields MAX_BURST beats, plus one idle cycle per grant.
- `gnt` is always one-hot or zero. `busy` == |`gnt`.

Optional Feature:
- Macro: FIFO_WR_ARB_PRIO0_EN.
- When defined: in IDLE, if `req_valid[0]` is high, requester 0 wins regardless of last_gnt.
  - last_gnt is not updated by a priority grant, so the rotation among requesters 1..N_REQ-1 resumes where it left off.
  - Burst and exit rules are unchanged; a running burst is never pre-empted.
- When undefined: pure round-robin as above.

Test Plan:
- Reset then all four requesters valid with constant data 0x10,0x20,0x30,0x40; FIFO drained continuously -> FIFO receives 4x0x10, 4x0x20, 4x0x30, 4x0x40, then repeats. `gnt` sequence 1,2,4,8. One `fifo_wr`-low cycle between bursts.
- Only requester 2 valid for 2 beats (0xA1,0xA2), then drops -> 2 writes, then exit to IDLE on the first valid-low cycle. Next grant search starts at requester 3.
- Fill the FIFO to 15 entries; requester 1 bursts 0x01..0x04 with no reads -> 0x01 is written, then `full`. `req_ready[1]`=0 and `fifo_wr`=0 for as long as `full` holds; FIFO `overflow` never asserts. After 3 reads, 0x02..0x04 complete and the burst ends at beat 4.
- `rst` asserted in the middle of requester 3's burst (after beat 2) -> next cycle `gnt`=0, `busy`=0, `fifo_wr`=0. After release with all requesters valid, requester 0 is granted first.
- With FIFO_WR_ARB_PRIO0_EN defined, requesters 0 and 2 continuously valid -> grants 0,0,0,... Requester 2 is granted only after requester 0 deasserts valid; without the macro, grants alternate 0,2,0,2.
- Randomised cross-check with all `req_valid` toggling and random FIFO reads -> scoreboard shows per-requester order preserved, no beat lost or duplicated, `gnt` one-hot or zero, `fifo_wr` && `fifo_full` never high together.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers.
// Optional feature: define FIFO_WR_ARB_PRIO0_EN to give requester 0 fixed priority in IDLE.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    input  logic                fifo_full,
    output logic                fifo_wr,
    output logic [DW-1:0]       fifo_din,
    output logic [N_REQ-1:0]    gnt,
    output logic                busy
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] pick_idx;
    logic [IdxW-1:0] cand;
    logic            pick_found;
    logic            owner_valid;
    logic            beat;

    // Search last_q+1, last_q+2, ... modulo N_REQ for the first valid requester.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IdxW'((32'(last_q) + i) % N_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign owner_valid = req_valid[owner_q];
    assign beat        = (state_q == StBurst) && owner_valid && !fifo_full && !rst;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (pick_found) begin
`ifdef FIFO_WR_ARB_PRIO0_EN
                    // Priority grants leave last_q alone so the rotation resumes unchanged.
                    if (req_valid[0]) begin
                        owner_d = '0;
                    end else begin
                        owner_d = pick_idx;
                        last_d  = pick_idx;
                    end
`else
                    owner_d = pick_idx;
                    last_d  = pick_idx;
`endif
                    cnt_d   = '0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (!owner_valid) begin
                    state_d = StIdle;
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(MAX_BURST - 1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= IdxW'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs are suppressed while rst is high so an abandoned burst never writes.
    always_comb begin
        gnt       = '0;
        req_ready = '0;
        fifo_wr   = 1'b0;
        fifo_din  = '0;
        if (state_q == StBurst) begin
            gnt[owner_q] = 1'b1;
            if (!rst) begin
                req_ready[owner_q] = !fifo_full;
                fifo_wr            = owner_valid && !fifo_full;
            end
        end
        if (fifo_wr) begin
            fifo_din = req_data[owner_q*DW +: DW];
        end
    end

    assign busy = (state_q == StBurst);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues, a 16-deep FIFO environment and a
// transaction-level arbitration model predicting every output each cycle.
module tb_fifo_wr_arbiter;

    localparam int N_REQ     = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                fifo_full;
    logic                fifo_wr;
    logic [DW-1:0]       fifo_din;
    logic [N_REQ-1:0]    gnt;
    logic                busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N_REQ    (N_REQ),
        .DW       (DW),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .fifo_full(fifo_full),
        .fifo_wr  (fifo_wr),
        .fifo_din (fifo_din),
        .gnt      (gnt),
        .busy     (busy)
    );

    logic [DW-1:0]    prod_q [N_REQ][$];
    logic [DW-1:0]    fifo_m [$];
    logic [N_REQ-1:0] gate;
    logic             rd;
    int               seq [N_REQ];

    // Reference model: who owns the port, how many beats it has moved, who was last.
    bit m_busy;
    int m_owner, m_last, m_beats;

    int n_checks, n_errors;
    int wr_count, exp_wr_count;
    int gnt_hist [$];
    logic [N_REQ-1:0] prev_gnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N_REQ; i++) begin
            req_valid[i] = (prod_q[i].size() != 0) && gate[i];
            req_data[i*DW +: DW] = (prod_q[i].size() != 0) ? prod_q[i][0] : '0;
        end
        fifo_full = (fifo_m.size() == DEPTH);
    endtask

    task automatic model_step();
        int pick;
        int c;
        if (rst) begin
            m_busy  = 0;
            m_last  = N_REQ - 1;
            m_beats = 0;
        end else if (!m_busy) begin
            if (req_valid != '0) begin
                pick = -1;
`ifdef FIFO_WR_ARB_PRIO0_EN
                if (req_valid[0]) pick = 0;
`endif
                if (pick < 0) begin
                    for (int k = 1; k <= N_REQ; k++) begin
                        c = (m_last + k) % N_REQ;
                        if (pick < 0 && req_valid[c]) pick = c;
                    end
                    m_last = pick;
                end
                m_owner = pick;
                m_busy  = 1;
                m_beats = 0;
            end
        end else begin
            if (!req_valid[m_owner]) begin
                m_busy = 0;
            end else if (!fifo_full) begin
                void'(prod_q[m_owner].pop_front());
                exp_wr_count++;
                m_beats++;
                if (m_beats == MAX_BURST) m_busy = 0;
            end
        end
    endtask

    // One clock: drive at negedge, check at negedge+1, advance model/environment at posedge.
    task automatic cycle();
        logic [N_REQ-1:0] exp_gnt, exp_ready;
        logic             exp_wr;
        logic [DW-1:0]    exp_din;
        logic             wr_s;
        logic [DW-1:0]    din_s;
        bit               can_pop;
        drive_inputs();
        #1;
        exp_gnt   = m_busy ? N_REQ'(1 << m_owner) : '0;
        exp_ready = (m_busy && !rst && !fifo_full) ? N_REQ'(1 << m_owner) : '0;
        exp_wr    = m_busy && !rst && req_valid[m_owner] && !fifo_full;
        exp_din   = exp_wr ? prod_q[m_owner][0] : '0;
        check_eq("gnt", 32'(gnt), 32'(exp_gnt));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("fifo_wr", 32'(fifo_wr), 32'(exp_wr));
        check_eq("fifo_din", 32'(fifo_din), 32'(exp_din));
        check_eq("no_overflow", 32'(fifo_wr & fifo_full), 32'd0);
        check_eq("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        if (gnt != '0 && prev_gnt == '0) gnt_hist.push_back(int'(gnt));
        prev_gnt = gnt;
        wr_s  = fifo_wr;
        din_s = fifo_din;
        @(posedge clk);
        can_pop = (fifo_m.size() != 0);
        if (wr_s) begin
            wr_count++;
            if (fifo_m.size() < DEPTH) fifo_m.push_back(din_s);
        end
        if (rd && can_pop) void'(fifo_m.pop_front());
        model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int t = 0; t < n; t++) cycle();
    endtask

    task automatic clear_producers();
        for (int i = 0; i < N_REQ; i++) prod_q[i].delete();
    endtask

    initial begin
        int wc0;
        int exp_seq;
        bit reached;
        n_checks = 0; n_errors = 0; wr_count = 0; exp_wr_count = 0;
        rst = 1'b1; rd = 1'b1; gate = '1; prev_gnt = '0;
        req_valid = '0; req_data = '0; fifo_full = 1'b0;
        m_busy = 0; m_owner = 0; m_last = N_REQ - 1; m_beats = 0;
        for (int i = 0; i < N_REQ; i++) seq[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle();
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_fifo_wr", 32'(fifo_wr), 32'd0);
        rst = 1'b0;

        // Rotation with everyone valid and constant data, FIFO drained every cycle.
        for (int i = 0; i < N_REQ; i++)
            for (int k = 0; k < 40; k++) prod_q[i].push_back(DW'((i + 1) * 16));
        gnt_hist.delete();
        run(40);
        check_eq("rot_count", 32'(gnt_hist.size() >= 8), 32'd1);
        for (int k = 0; k < 8 && k < gnt_hist.size(); k++) begin
`ifdef FIFO_WR_ARB_PRIO0_EN
            exp_seq = 1;
`else
            exp_seq = 1 << (k % N_REQ);
`endif
            check_eq("rot_seq", 32'(gnt_hist[k]), 32'(exp_seq));
        end
        clear_producers();
        run(20);

        // Requester 2 alone for two beats; next search starts at requester 3.
        prod_q[2].push_back(8'hA1);
        prod_q[2].push_back(8'hA2);
        wc0 = wr_count;
        run(8);
        check_eq("short_burst_writes", 32'(wr_count - wc0), 32'd2);
        prod_q[0].push_back(8'h0F);
        prod_q[3].push_back(8'h3F);
        run(1);
`ifdef FIFO_WR_ARB_PRIO0_EN
        check_eq("rr_resume", 32'(gnt), 32'h1);
`else
        check_eq("rr_resume", 32'(gnt), 32'h8);
`endif
        run(10);

        // Fill FIFO to 15, then requester 1 bursts into the last entry and stalls on full.
        rd = 1'b0;
        for (int k = 0; k < 15; k++) prod_q[0].push_back(DW'(8'h50 + k));
        for (int t = 0; t < 80 && fifo_m.size() < 15; t++) cycle();
        check_eq("fill15", 32'(fifo_m.size()), 32'd15);
        run(3);
        for (int k = 1; k <= 4; k++) prod_q[1].push_back(DW'(k));
        wc0 = wr_count;
        run(12);
        check_eq("full_stall_writes", 32'(wr_count - wc0), 32'd1);
        check_eq("full_level", 32'(fifo_m.size()), 32'd16);
        rd = 1'b1;
        run(3);
        rd = 1'b0;
        run(8);
        check_eq("full_resume_writes", 32'(wr_count - wc0), 32'd4);
        check_eq("burst_end_idle", 32'(busy), 32'd0);
        rd = 1'b1;
        run(20);

        // Reset in the middle of requester 3's burst after beat 2.
        for (int k = 0; k < 8; k++) prod_q[3].push_back(DW'(8'hC0 + k));
        reached = 0;
        for (int t = 0; t < 20 && !reached; t++) begin
            cycle();
            reached = m_busy && m_owner == 3 && m_beats == 2;
        end
        check_eq("rst_setup", 32'(reached), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check_eq("rst_mid_gnt", 32'(gnt), 32'd0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_wr", 32'(fifo_wr), 32'd0);
        for (int i = 0; i < N_REQ; i++)
            for (int k = 0; k < 4; k++) prod_q[i].push_back(DW'(8'hE0 + i * 4 + k));
        run(1);
        check_eq("post_rst_first", 32'(gnt), 32'h1);
        run(60);

        // Randomised traffic: toggling valids, random reads, per-requester sequence data.
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if ($urandom_range(0, 3) == 0 && prod_q[i].size() < 6) begin
                    prod_q[i].push_back(DW'(i * 32 + (seq[i] % 32)));
                    seq[i]++;
                end
                gate[i] = ($urandom_range(0, 3) != 0);
            end
            rd = (t < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            cycle();
        end
        gate = '1;
        rd = 1'b1;
        run(120);
        check_eq("beats_total", 32'(wr_count), 32'(exp_wr_count));
        for (int i = 0; i < N_REQ; i++)
            check_eq("producer_drained", 32'(prod_q[i].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
